// File: rtl/mp8_bus_pkg.sv
// Shared definitions for the mp8 memory bus: default widths, port IDs and lock-state encodings.
package mp8_bus_pkg;

   localparam int MP8_ADDR_W = 16;
   localparam int MP8_DATA_W = 8;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_st_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner select for the memory arbiter; purely combinational, one-hot gnt.
// Latency 0; a requester that loses simply sees gnt low and keeps its request up.
// Precedence: forced release, then lock owner, then contention rule (port != rr_ptr).
module mem_arb_pick
   import mp8_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_ptr,
   input  logic       locked,
   input  logic       owner,
   input  logic       force_release,
   output logic [1:0] gnt
);

   logic other;
   logic rr_win;

   assign other  = ~owner;
   assign rr_win = ~rr_ptr;

   always_comb begin
      gnt = 2'b00;
      if (force_release) begin
         gnt[other] = req[other];
      end else if (locked) begin
         gnt[owner] = req[owner];
      end else if (&req) begin
         gnt[rr_win] = 1'b1;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for the 64K x 8 memory with bounded RMW bus lock.
// Latency: grant is combinational, read data returns one cycle after the grant.
// Backpressure: losers hold req until gnt; MEM_ARB_RR_EN selects round-robin over fixed CPU priority.
module mem_arbiter
   import mp8_bus_pkg::*;
#(
   parameter int ADDR_W   = MP8_ADDR_W,
   parameter int DATA_W   = MP8_DATA_W,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p0_lock,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic              p1_lock,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner
);

   localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

   lock_st_t          state_q, state_d;
   logic              owner_q, owner_d;
   logic [3:0]        lock_cnt_q, lock_cnt_d;
   logic              boot_hold;
   logic              rr_ptr;
   logic              rd_vld_q;
   logic              rd_port_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        req_g;
   logic [1:0]        gnt;
   logic              locked;
   logic              force_release;
   logic              any;
   logic              win;
   logic              win_we;
   logic              win_lock;

   // The cycle after reset is held off so the memory's reset image can settle.
   always_ff @(posedge clk) begin
      if (rst) boot_hold <= 1'b1;
      else     boot_hold <= 1'b0;
   end

   assign req_g         = {p1_req, p0_req} & {2{~rst & ~boot_hold}};
   assign locked        = (state_q == ST_LOCKED);
   assign force_release = locked && (lock_cnt_q == LOCK_MAX_C) && req_g[~owner_q];

   mem_arb_pick u_pick (
      .req           (req_g),
      .rr_ptr        (rr_ptr),
      .locked        (locked),
      .owner         (owner_q),
      .force_release (force_release),
      .gnt           (gnt)
   );

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)      rr_ptr <= PORT_CPU;
      else if (any) rr_ptr <= win;
   end
`else
   // Pinning the pointer at DMA makes the contention rule always pick the CPU.
   assign rr_ptr = PORT_DMA;
`endif

   assign any      = |gnt;
   assign win      = gnt[1];
   assign win_we   = win ? p1_we   : p0_we;
   assign win_lock = win ? p1_lock : p0_lock;

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign mem_we    = any & win_we;
   assign mem_re    = any & ~win_we;
   assign mem_addr  = any ? (win ? p1_addr : p0_addr) : addr_q;
   assign mem_wdata = any ? (win ? p1_wdata : p0_wdata) : wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_vld_q  <= 1'b0;
         rd_port_q <= PORT_CPU;
      end else begin
         addr_q    <= mem_addr;
         wdata_q   <= mem_wdata;
         rd_vld_q  <= mem_re;
         rd_port_q <= win;
      end
   end

   assign p0_rvalid = rd_vld_q & ~rst & (rd_port_q == PORT_CPU);
   assign p1_rvalid = rd_vld_q & ~rst & (rd_port_q == PORT_DMA);
   assign p0_rdata  = mem_rdata;
   assign p1_rdata  = mem_rdata;
   assign owner     = owner_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_UNLOCKED;
         owner_q    <= PORT_CPU;
         lock_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      if (state_q == ST_UNLOCKED || force_release) begin
         if (any && win_lock) begin
            state_d    = ST_LOCKED;
            owner_d    = win;
            lock_cnt_d = 4'd1;
         end else begin
            state_d    = ST_UNLOCKED;
            owner_d    = PORT_CPU;
            lock_cnt_d = 4'd0;
         end
      end else if (any && win_lock) begin
         // Only the owner can be granted here; the count saturates.
         if (lock_cnt_q != LOCK_MAX_C) lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
         state_d    = ST_UNLOCKED;
         owner_d    = PORT_CPU;
         lock_cnt_d = 4'd0;
      end
   end

endmodule
